// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple chain of full-adder cells.
module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/subtract, LSB digit first, start/busy/done handshake.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] sreg;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic             dcmsb;
   logic [WIDTH-1:0] snext;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (areg[DIGIT-1:0]),
      .y     (breg[DIGIT-1:0]),
      .cin   (carry),
      .s     (dsum),
      .cout  (dcout),
      .c_msb (dcmsb)
   );

   // Written as shift/or so that DIGIT == WIDTH needs no zero-width slice.
   always_comb begin
      snext = (sreg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         areg   <= '0;
         breg   <= '0;
         sreg   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  areg  <= a;
                  breg  <= (mode == MODE_SUB) ? ~b : b;
                  carry <= mode;
                  cnt   <= '0;
                  sreg  <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               areg  <= areg >> DIGIT;
               breg  <= breg >> DIGIT;
               sreg  <= snext;
               carry <= dcout;
               cnt   <= cnt + CW'(1);
               // The last digit's c_msb is the carry into bit WIDTH-1.
               if (cnt == CW'(NDIG - 1)) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= snext;
                  cout   <= dcout;
                  ovf    <= dcmsb ^ dcout;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases on 16/4 plus a random sweep over four shapes.
module tb_serial_addsub;

   localparam int WV [4] = '{16, 16, 16, 8};
   localparam int NV [4] = '{4, 16, 1, 4};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        st [4];

   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic        cout0, cout1, cout2, cout3;
   logic        ovf0, ovf1, ovf2, ovf3;
   logic [15:0] res0, res1, res2;
   logic [7:0]  res3;

   logic        busy_v [4];
   logic        done_v [4];
   logic        cout_v [4];
   logic        ovf_v  [4];
   logic [15:0] res_v  [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .a(a), .b(b),
      .busy(busy0), .done(done0), .result(res0), .cout(cout0), .ovf(ovf0));
   serial_addsub #(.WIDTH(16), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .a(a), .b(b),
      .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1));
   serial_addsub #(.WIDTH(16), .DIGIT(16)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .a(a), .b(b),
      .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2));
   serial_addsub #(.WIDTH(8), .DIGIT(2)) u3 (
      .clk(clk), .rst(rst), .start(st[3]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
      .busy(busy3), .done(done3), .result(res3), .cout(cout3), .ovf(ovf3));

   assign busy_v[0] = busy0;  assign busy_v[1] = busy1;
   assign busy_v[2] = busy2;  assign busy_v[3] = busy3;
   assign done_v[0] = done0;  assign done_v[1] = done1;
   assign done_v[2] = done2;  assign done_v[3] = done3;
   assign cout_v[0] = cout0;  assign cout_v[1] = cout1;
   assign cout_v[2] = cout2;  assign cout_v[3] = cout3;
   assign ovf_v[0]  = ovf0;   assign ovf_v[1]  = ovf1;
   assign ovf_v[2]  = ovf2;   assign ovf_v[3]  = ovf3;
   assign res_v[0]  = res0;   assign res_v[1]  = res1;
   assign res_v[2]  = res2;   assign res_v[3]  = {8'h00, res3};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed operand values.
   function automatic logic [17:0] model(input int w, input bit m, input logic [15:0] x, input logic [15:0] y);
      longint mask, ux, uy, sx, sy, tot, sr, hi, lo;
      logic [15:0] r;
      logic c, v;
      mask = (longint'(1) << w) - 1;
      ux = longint'(x) & mask;
      uy = longint'(y) & mask;
      if (!m) begin
         tot = ux + uy;
         c   = (tot > mask);
      end else begin
         tot = ux - uy;
         c   = (ux >= uy);
      end
      r  = 16'(tot & mask);
      sx = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
      sy = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
      sr = m ? (sx - sy) : (sx + sy);
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      v  = (sr > hi) || (sr < lo);
      return {v, c, r};
   endfunction

   // One operation on instance k; junk keeps start high with other operands through RUN and DONE.
   task automatic run_op(input int k, input bit m, input logic [15:0] x, input logic [15:0] y,
                         input bit junk, output logic [17:0] obs);
      logic [17:0] prev, exp;
      int n, bc;
      bit stable, seen;
      string t;
      t = $sformatf("i%0d", k);
      exp = model(WV[k], m, x, y);
      @(negedge clk);
      mode = m; a = x; b = y; st[k] = 1'b1;
      prev = {ovf_v[k], cout_v[k], res_v[k]};
      @(posedge clk); #1;
      if (junk) begin
         a = 16'hAAAA; b = 16'h1111; mode = ~m;
      end else begin
         st[k] = 1'b0;
      end
      bc = busy_v[k] ? 1 : 0;
      stable = 1'b1;
      seen = 1'b0;
      n = 0;
      while (n < 40 && !seen) begin
         @(posedge clk); #1;
         n++;
         if (done_v[k]) seen = 1'b1;
         else begin
            if (busy_v[k]) bc++;
            if ({ovf_v[k], cout_v[k], res_v[k]} !== prev) stable = 1'b0;
         end
      end
      check({t, "_latency"}, n, NV[k]);
      check({t, "_busy_cycles"}, bc, NV[k]);
      check({t, "_stable_in_run"}, stable, 1'b1);
      check({t, "_busy_at_done"}, busy_v[k], 1'b0);
      obs = {ovf_v[k], cout_v[k], res_v[k]};
      check({t, "_ovf_cout_result"}, obs, exp);
      @(posedge clk); #1;
      st[k] = 1'b0;
      check({t, "_done_one_cycle"}, done_v[k], 1'b0);
      check({t, "_idle_after_done"}, busy_v[k], 1'b0);
   endtask

   initial begin
      logic [17:0] obs;
      int pulses;
      for (int i = 0; i < 4; i++) st[i] = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_busy%0d", k), busy_v[k], 1'b0);
         check($sformatf("rst_done%0d", k), done_v[k], 1'b0);
         check($sformatf("rst_flags_result%0d", k), {ovf_v[k], cout_v[k], res_v[k]}, '0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, obs);
      check("add_1234_0fff", obs, {1'b0, 1'b0, 16'h2233});
      run_op(0, 1'b1, 16'h0005, 16'h0007, 1'b0, obs);
      check("sub_5_7", obs, {1'b0, 1'b0, 16'hFFFE});
      run_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0, obs);
      check("sub_8000_1", obs, {1'b1, 1'b1, 16'h7FFF});
      run_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, obs);
      check("add_7fff_1", obs, {1'b1, 1'b0, 16'h8000});
      run_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, obs);
      check("add_ffff_1", obs, {1'b0, 1'b1, 16'h0000});
      run_op(0, 1'b0, 16'h1234, 16'h0FFF, 1'b1, obs);
      check("repulse_ignored", obs, {1'b0, 1'b0, 16'h2233});

      // Reset asserted during the second RUN cycle.
      @(negedge clk);
      a = 16'h1234; b = 16'h0FFF; mode = 1'b0; st[0] = 1'b1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", busy0, 1'b0);
      check("midrst_done", done0, 1'b0);
      check("midrst_result", res0, 16'h0000);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done0) pulses++;
      end
      check("midrst_no_done", pulses, 0);
      run_op(0, 1'b1, 16'h0003, 16'h0001, 1'b0, obs);
      check("after_rst_sub_3_1", obs, {1'b0, 1'b1, 16'h0002});

      for (int k = 0; k < 4; k++) begin
         for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
               run_op(k, bit'(m), 16'($urandom), 16'($urandom), 1'b0, obs);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised, digit-serial two's-complement add/subtract unit. It is the multi-cycle successor to the 4-bit ripple subtractor.
- Processes DIGIT bits per clock through a D-bit ripple chain, LSB digit first.
- Supports add and subtract modes, plus unsigned carry/borrow and signed-overflow flags.
- Uses a start/busy/done handshake, so it sits beside datapath controllers that trade latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle completion pulse (high in DONE).
result  output  WIDTH  final sum/difference; held until the next completion.
cout  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow (a >= b unsigned).
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset values: state = IDLE; busy, done, cout, ovf = 0; result = 0; all internal registers = 0. rst takes priority over every other input.
- Subtraction uses b inverted and initial carry = 1; addition uses b and initial carry = 0. The initial carry is loaded from mode at accept.
- IDLE: if start = 1, latch a, b (inverted when mode = 1), set carry = mode and digit count = 0, go to RUN. Otherwise stay in IDLE.
- RUN: each edge processes digit cnt.
  - Combine the low DIGIT bits of the A and B shift registers with the carry register.
  - Shift the sum digit into the result shift register from the top.
  - Shift both operand registers right by DIGIT.
  - Update the carry register and increment cnt.
- RUN end: on the edge where cnt = NDIG-1, go to DONE and in the same edge:
  - load result from the completed shift register;
  - cout = carry out of that digit;
  - ovf = carry into bit WIDTH-1 XOR cout.
- DONE: done = 1 for exactly one cycle, busy = 0; next state is always IDLE.
- Latency: the start-accepting edge is E0. done is high in the cycle following edge E_NDIG. The next start is accepted in the cycle after DONE, giving throughput of one operation per NDIG+2 cycles.
- start in RUN or DONE is ignored; operands and mode changes are ignored outside IDLE.
- result, cout and ovf change only on the completion edge (or on reset); they are stable during RUN.
- Wrap-around: result is modulo 2^WIDTH. Flags are reported and never saturate.
- NDIG = 1 (DIGIT = WIDTH): RUN lasts one cycle.
- DIGIT = 1: pure bit-serial operation with WIDTH RUN cycles.
- Reset mid-operation: on the next edge the block returns to IDLE with the reset values above. The partial result is discarded and no done pulse is produced.

Decomposition:
- Package serial_addsub_pkg: state enum (IDLE, RUN, DONE), MODE_ADD = 1'b0 and MODE_SUB = 1'b1 constants.
- Sub-module addsub_digit (parametrised by DIGIT), a combinational ripple chain of full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], cin.
  - Outputs: s[DIGIT], cout, c_msb (carry into the top bit of the digit).
- The top level holds the FSM, counter, shift registers and flag logic.

Test Plan:
- Add, WIDTH=16, DIGIT=4: 0x1234 + 0x0FFF -> result 0x2233, cout 0, ovf 0; busy high for exactly 4 cycles, done high for 1 cycle.
- Subtract: 0x0005 - 0x0007 -> 0xFFFE, cout 0 (borrow), ovf 0. Subtract 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1.
- Add boundaries: 0x7FFF + 0x0001 -> 0x8000, cout 0, ovf 1. 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0.
- start re-pulsed with 0xAAAA/0x1111 during RUN and during DONE -> ignored; the first operation's result appears unchanged and only one done pulse occurs.
- rst asserted in the 2nd RUN cycle -> next edge: busy 0, done 0, result 0; no done pulse follows. A later start of 0x0003 - 0x0001 -> 0x0002, cout 1.
- Parameter sweep (DIGIT=1, DIGIT=16, WIDTH=8/DIGIT=2) with 1000 random operand pairs per mode -> result and flags match a reference model; done occurs exactly NDIG cycles after the accepting edge.
